// File: rtl/qe_multi_channel.sv
// Multi-channel quadrature encoder interface: per-channel sync, glitch
// filter, 4x decode, index capture, period timer, shared register port.

module qe_channel #(
  parameter int COUNT_W  = 32,
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pin_i,
  input  logic        wr_i,
  input  logic [2:0]  reg_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam logic [PERIOD_W-1:0] PMAX  = '1;
  localparam logic [PERIOD_W-1:0] PNEAR = PMAX - PERIOD_W'(1);

  logic [2:0]          s1_q, s2_q, filt_q;
  logic [3:0]          fcnt_q [3];
  logic [1:0]          ab_q;
  logic                i_q;

  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [COUNT_W-1:0]  cap_q, cap_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] tmr_q, tmr_d;
  logic [9:0]          cfg_q, cfg_d;
  logic                seen_q, seen_d;
  logic                perr_q, perr_d;
  logic                ovf_q, ovf_d;
  logic                dir_q, dir_d;

  logic       en, flip, iclr, ien, een;
  logic [3:0] flen;
  logic [1:0] cur_ab;
  logic       fwd, rev, step, perr_ev, idx, ovf_set;
  logic       wr_cnt, wr_cfg, wr_st;

  assign en   = cfg_q[0];
  assign flip = cfg_q[1];
  assign iclr = cfg_q[2];
  assign flen = cfg_q[7:4];
  assign ien  = cfg_q[8];
  assign een  = cfg_q[9];

  // Sync, filter and decoder history run regardless of enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      ab_q   <= '0;
      i_q    <= 1'b0;
      for (int k = 0; k < 3; k++) fcnt_q[k] <= '0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
      ab_q <= cur_ab;
      i_q  <= filt_q[2];
      for (int k = 0; k < 3; k++) begin
        if (s2_q[k] != filt_q[k]) begin
          if (fcnt_q[k] == flen) begin
            filt_q[k] <= s2_q[k];
            fcnt_q[k] <= '0;
          end else begin
            fcnt_q[k] <= fcnt_q[k] + 4'd1;
          end
        end else begin
          fcnt_q[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    cur_ab = flip ? {filt_q[1], filt_q[0]}
                  : {filt_q[0], filt_q[1]};
    fwd = 1'b0;
    rev = 1'b0;
    unique case ({ab_q, cur_ab})
      4'b0010, 4'b1011,
      4'b1101, 4'b0100: fwd = 1'b1;
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: rev = 1'b1;
      default: ;
    endcase
    perr_ev = en & ((ab_q ^ cur_ab) == 2'b11);
    step    = en & (fwd | rev);
    idx     = en & filt_q[2] & ~i_q;
    wr_cnt  = wr_i & (reg_i == 3'd0);
    wr_cfg  = wr_i & (reg_i == 3'd3);
    wr_st   = wr_i & (reg_i == 3'd4);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr_cnt)
      cnt_d = wdata_i[COUNT_W-1:0];
    else if (idx & iclr)
      cnt_d = '0;
    else if (en & fwd)
      cnt_d = cnt_q + COUNT_W'(1);
    else if (en & rev)
      cnt_d = cnt_q - COUNT_W'(1);

    cap_d = idx ? cnt_q : cap_q;

    tmr_d   = tmr_q;
    per_d   = per_q;
    ovf_set = 1'b0;
    if (!en) begin
      tmr_d = '0;
    end else if (step) begin
      tmr_d = '0;
      per_d = tmr_q;
    end else if (tmr_q != PMAX) begin
      tmr_d = tmr_q + PERIOD_W'(1);
      if (tmr_q == PNEAR) begin
        per_d   = PMAX;
        ovf_set = 1'b1;
      end
    end

    dir_d  = step ? fwd : dir_q;
    seen_d = idx | (seen_q & ~(wr_st & wdata_i[0]));
    perr_d = perr_ev | (perr_q & ~(wr_st & wdata_i[1]));
    ovf_d  = ovf_set | (ovf_q & ~(wr_st & wdata_i[2]));
    cfg_d  = wr_cfg ? {wdata_i[9:4], 1'b0, wdata_i[2:0]}
                    : cfg_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      cap_q  <= '0;
      per_q  <= '0;
      tmr_q  <= '0;
      cfg_q  <= '0;
      seen_q <= 1'b0;
      perr_q <= 1'b0;
      ovf_q  <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
      per_q  <= per_d;
      tmr_q  <= tmr_d;
      cfg_q  <= cfg_d;
      seen_q <= seen_d;
      perr_q <= perr_d;
      ovf_q  <= ovf_d;
      dir_q  <= dir_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    unique case (reg_i)
      3'd0: rdata_o = 32'(cnt_q);
      3'd1: rdata_o = 32'(cap_q);
      3'd2: rdata_o = 32'(per_q);
      3'd3: rdata_o = {22'd0, cfg_q};
      3'd4: rdata_o = {25'd0, filt_q, dir_q,
                       ovf_q, perr_q, seen_q};
      default: rdata_o = '0;
    endcase
  end

  assign irq_o = (seen_q & ien) | (perr_q & een);

endmodule

module qe_multi_channel #(
  parameter int NUM_CH   = 4,
  parameter int COUNT_W  = 32,
  parameter int PERIOD_W = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          qe_a,
  input  logic [NUM_CH-1:0]          qe_b,
  input  logic [NUM_CH-1:0]          qe_i,
  input  logic [$clog2(NUM_CH)+2:0]  addr,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic                       rd_en,
  output logic [31:0]                rd_data,
  output logic                       rd_valid,
  output logic                       irq
);

  localparam int AW  = $clog2(NUM_CH) + 3;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CHW-1:0]    ch_sel;
  logic [31:0]       rword [NUM_CH];
  logic [NUM_CH-1:0] irq_src;
  logic [31:0]       rsel;
  logic [31:0]       rd_data_q;
  logic              rd_valid_q, irq_q;

  if (NUM_CH > 1) begin : g_sel
    assign ch_sel = addr[AW-1:3];
  end else begin : g_sel1
    assign ch_sel = '0;
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    qe_channel #(
      .COUNT_W  (COUNT_W),
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .pin_i   ({qe_i[n], qe_b[n], qe_a[n]}),
      .wr_i    (wr_en && (ch_sel == CHW'(n))),
      .reg_i   (addr[2:0]),
      .wdata_i (wr_data),
      .rdata_o (rword[n]),
      .irq_o   (irq_src[n])
    );
  end

  // Unpopulated channel slots read as zero
  always_comb begin
    rsel = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (ch_sel == CHW'(n)) rsel = rword[n];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_en ? rsel : '0;
      rd_valid_q <= rd_en;
      irq_q      <= |irq_src;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_qe_multi_channel.sv
// Scoreboard bench for qe_multi_channel: reads push expected values,
// a monitor pops and compares on every rd_valid.

module tb_qe_multi_channel;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  qe_a = '0;
  logic [3:0]  qe_b = '0;
  logic [3:0]  qe_i = '0;
  logic [4:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;

  int nvec = 0;
  int nmis = 0;
  logic [31:0] exp_q [$];
  string       nm_q [$];
  int          pos [4];

  always #5 clk = ~clk;

  qe_multi_channel #(
    .NUM_CH   (4),
    .COUNT_W  (32),
    .PERIOD_W (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .qe_a     (qe_a),
    .qe_b     (qe_b),
    .qe_i     (qe_i),
    .addr     (addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq)
  );

  initial begin : monitor
    logic [31:0] e;
    string n;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nmis++;
          $display("FAIL unexpected_read got %h expected none",
                   rd_data);
        end else begin
          e = exp_q.pop_front();
          n = nm_q.pop_front();
          if (rd_data !== e) begin
            nmis++;
            $display("FAIL %s got %h expected %h", n, rd_data, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rd(input int ch, input int r,
                    input logic [31:0] exp, input string nm);
    logic [1:0] c;
    logic [2:0] g;
    c = ch[1:0];
    g = r[2:0];
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    addr  = {c, g};
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wr(input int ch, input int r,
                    input logic [31:0] d);
    logic [1:0] c;
    logic [2:0] g;
    c = ch[1:0];
    g = r[2:0];
    addr    = {c, g};
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rdwr(input int ch, input int r,
                      input logic [31:0] d,
                      input logic [31:0] exp, input string nm);
    logic [1:0] c;
    logic [2:0] g;
    c = ch[1:0];
    g = r[2:0];
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    addr    = {c, g};
    wr_data = d;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // One quadrature edge, then 10 clocks of quiet
  task automatic move(input int ch, input int d);
    logic [1:0] ab;
    pos[ch] += d;
    ab = ab_of(pos[ch]);
    qe_a[ch] = ab[1];
    qe_b[ch] = ab[0];
    idle(10);
  endtask

  initial begin : stim
    for (int c = 0; c < 4; c++) pos[c] = 0;
    idle(1);
    chk("rd_valid_rst", {31'd0, rd_valid}, 32'd0);
    idle(2);
    reset = 1'b1;
    idle(2);

    for (int r = 0; r < 8; r++) rd(0, r, 32'd0, "rst_reg");
    chk("irq_rst", {31'd0, irq}, 32'd0);

    wr(0, 3, 32'h1);
    for (int k = 0; k < 16; k++) move(0, 1);
    rd(0, 0, 32'd16, "fwd_count");
    rd(0, 2, 32'd9, "fwd_period");
    rd(0, 4, 32'h8, "fwd_status");
    for (int k = 0; k < 20; k++) move(0, -1);
    rd(0, 0, 32'hFFFF_FFFC, "rev_count");
    rd(0, 2, 32'd9, "rev_period");
    rd(0, 4, 32'h0, "rev_status");

    wr(1, 3, 32'h31);
    idle(5);
    qe_a[1] = 1'b1;
    idle(3);
    qe_a[1] = 1'b0;
    idle(10);
    rd(1, 0, 32'd0, "glitch_count");
    qe_a[1] = 1'b1;
    pos[1] = 1;
    idle(6);
    rd(1, 0, 32'd0, "filt_edge6");
    rd(1, 0, 32'd1, "filt_edge7");
    rd(1, 4, 32'h18, "filt_status");
    rd(1, 3, 32'h31, "cfg_readback");

    wr(2, 3, 32'h105);
    wr(2, 0, 32'd100);
    qe_i[2] = 1'b1;
    idle(4);
    chk("irq_idx_early", {31'd0, irq}, 32'd0);
    idle(1);
    chk("irq_idx_set", {31'd0, irq}, 32'd1);
    idle(5);
    rd(2, 1, 32'd100, "index_cap");
    rd(2, 0, 32'd0, "index_clear");
    rd(2, 4, 32'h41, "index_status");
    wr(2, 4, 32'h1);
    chk("irq_w1c_lag", {31'd0, irq}, 32'd1);
    idle(1);
    chk("irq_w1c_clr", {31'd0, irq}, 32'd0);
    rd(2, 4, 32'h40, "index_w1c");

    wr(3, 3, 32'h201);
    qe_a[3] = 1'b1;
    qe_b[3] = 1'b1;
    idle(8);
    rd(3, 0, 32'd0, "perr_count");
    rd(3, 4, 32'h32, "perr_status");
    chk("irq_perr", {31'd0, irq}, 32'd1);
    wr(3, 4, 32'h2);
    idle(1);
    chk("irq_perr_clr", {31'd0, irq}, 32'd0);
    qe_a[3] = 1'b0;
    idle(3);
    wr(3, 0, 32'd5);
    idle(5);
    rd(3, 0, 32'd5, "wr_beats_step");
    rd(3, 4, 32'h28, "wr_step_status");

    rdwr(1, 0, 32'd77, 32'd1, "rdwr_old");
    rd(1, 0, 32'd77, "rdwr_new");
    wr(1, 5, 32'hFFFF_FFFF);
    rd(1, 5, 32'd0, "reg5_zero");
    rd(1, 6, 32'd0, "reg6_zero");

    idle(300);
    rd(0, 2, 32'hFF, "ovf_period");
    rd(0, 4, 32'h4, "ovf_status");
    wr(0, 3, 32'h0);
    for (int k = 0; k < 4; k++) move(0, 1);
    rd(0, 0, 32'hFFFF_FFFC, "dis_count");
    rd(0, 2, 32'hFF, "dis_period");
    rd(0, 4, 32'h4, "dis_status");

    idle(1);
    reset = 1'b0;
    idle(2);
    chk("rd_valid_midrst", {31'd0, rd_valid}, 32'd0);
    chk("irq_midrst", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    idle(1);
    rd(1, 0, 32'd0, "midrst_count");
    rd(1, 3, 32'd0, "midrst_cfg");

    idle(3);
    nvec++;
    if (exp_q.size() != 0) begin
      nmis++;
      $display("FAIL pending_reads got %0d expected 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/qe_multi_channel.md
# qe_multi_channel

Parametrised multi-channel quadrature encoder interface. It is the next generation of the single-channel QE block. Each channel synchronises and glitch-filters external A/B/I inputs, then performs 4x decoding into a wide position counter. Per channel it also captures position on index, measures the edge-to-edge period for speed, and flags illegal phase transitions. All channels share a simple registered read/write register port and a single interrupt line, and the block sits on the internal bus side of the motion subsystem.

## Interface
- NUM_CH, 4, number of encoder channels (1..8)
- COUNT_W, 32, position counter width (16..32); reads are zero-extended to 32 bits
- PERIOD_W, 24, period timer width (8..32)
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low; clock clk
- qe_a, qe_b, qe_i  in  NUM_CH each  asynchronous encoder inputs, bit n = channel n
- addr  in  $clog2(NUM_CH)+3  register address = {channel, reg[2:0]}
- wr_en  in  1  write strobe, one cycle
- wr_data  in  32  write data
- rd_en  in  1  read strobe, one cycle
- rd_data  out  32  read data, valid with rd_valid, 0 otherwise
- rd_valid  out  1  read data valid
- irq  out  1  registered OR of enabled channel interrupt sources

## Operation
- Registers per channel:
  - reg 0 COUNT: RW; a write preloads the counter.
  - reg 1 INDEX_CAP: RO.
  - reg 2 PERIOD: RO.
  - reg 3 CONFIG: RW.
    - bit0 enable
    - bit1 flip_ab
    - bit2 index_clear
    - bits7:4 filter_len
    - bit8 irq_index_en
    - bit9 irq_error_en
  - reg 4 STATUS.
    - bit0 index_seen, W1C
    - bit1 phase_error, W1C
    - bit2 period_ovf, W1C
    - bit3 direction, RO, 1 = forward
    - bits6:4 filtered {I,B,A}, RO
  - regs 5-7 read 0; writes to them are ignored.
- Synchroniser: 2 flops per input.
- Filter: per input, a counter tracks consecutive cycles in which the synchronised input differs from the filtered output. The output takes the new level once the difference has persisted filter_len+1 cycles. Any cycle of agreement clears the counter.
- flip_ab swaps the filtered A and B before decoding.
- Decoder: a state register holds the previous {A,B}.
  - Forward sequence: 00→10→11→01→00. A forward step increments COUNT and sets direction=1.
  - A reverse step decrements COUNT and sets direction=0.
  - No change: no action.
  - Both bits change in one cycle: phase_error is set, there is no count, and the state register still updates.
- COUNT wraps modulo 2^COUNT_W in both directions, with no saturation.
- Index: on a rising edge of filtered I:
  - INDEX_CAP takes the COUNT value held before this cycle's update.
  - index_seen is set.
  - If index_clear=1, COUNT becomes 0, overriding a same-cycle count step.
- Period: a timer counts clk cycles since the last count step. On each step, PERIOD takes the timer value and the timer restarts at 0.
  - When the timer reaches all-ones it holds there.
  - At that point PERIOD is forced to all-ones and period_ovf is set.
- enable=0:
  - Synchroniser, filter and decoder state keep running.
  - COUNT does not change, apart from register writes.
  - The timer is held at 0.
  - PERIOD and INDEX_CAP retain their values.
  - No status flags are set.
- Priority on COUNT within one cycle: register write > index_clear > count step.
- Priority on a status flag within one cycle: set beats W1C clear.
- irq = OR over channels of (index_seen & irq_index_en) | (phase_error & irq_error_en).

## Timing
- Reset values:
  - All registers, counters, filtered outputs and decoder state are 0.
  - rd_data=0, rd_valid=0, irq=0.
- Input to COUNT latency: COUNT changes filter_len+4 clk edges after the first edge that samples the new input level. This breaks down as 2 (sync) + filter_len+1 (filter) + 1 (decode/update).
- Writes take effect on the clk edge where wr_en=1.
- Reads:
  - rd_en at edge k gives rd_valid=1 and rd_data after edge k+1, for one cycle.
  - Back-to-back reads are supported every cycle.
  - A read and a write to the same address in the same cycle return the old value.
- irq updates one cycle after the status or config change that causes it.
- Reset asserted mid-operation clears everything immediately (asynchronously). rd_valid drops during reset.

## Test plan
- Reset behaviour: reset pulse, then read all 8 regs of channel 0 → all read 0, irq=0.
- Forward and reverse counting: ch0 enable=1, filter_len=0; drive 4 forward cycles (16 edges) spaced 10 clk apart → COUNT=16, direction=1, PERIOD=9. Then drive 20 reverse edges → COUNT=0xFFFFFFFC, direction=0.
- Glitch filter: ch1 filter_len=3. A 3-cycle glitch on A causes no count. A 4-cycle stable change gives +1, observed exactly 7 clk edges after the change.
- Index handling: ch2 index_clear=1, COUNT preloaded to 100. An I rising edge gives INDEX_CAP=100, COUNT=0 and index_seen=1; with irq_index_en=1, irq goes to 1 one cycle later. Writing STATUS=1 then clears irq.
- Phase error: A and B toggle in the same cycle → phase_error=1, COUNT unchanged. Same-cycle COUNT write of 5 during a forward step → COUNT=5.
- Period overflow and disable: with PERIOD_W=8, no edges for 300 cycles → PERIOD=0xFF and period_ovf=1. Setting enable=0 and driving edges leaves COUNT and PERIOD unchanged.
